// File: rtl/debounce_botao_enter_pkg.sv
// Shared definitions for the enter-key conditioning path: debounce FSM
// state encoding and the default timing constants for a 50 MHz clock.
package pkg_entrada;

    // Debounce FSM states, 2-bit encoding
    typedef enum logic [1:0] {
        SOLTO          = 2'd0,
        CONFIRMA_PRESS = 2'd1,
        PRESSIONADO    = 2'd2,
        CONFIRMA_SOLTA = 2'd3
    } estado_botao_t;

    // 10 ms of stable input at 50 MHz
    localparam int CICLOS_ESTAVEL_PADRAO    = 500000;
    // 0.5 s hold before the first auto-repeat pulse
    localparam int ATRASO_REPETICAO_PADRAO  = 25000000;
    // 0.1 s between subsequent auto-repeat pulses
    localparam int PERIODO_REPETICAO_PADRAO = 5000000;
    // Wide enough for the default stable-cycle count
    localparam int LARGURA_CONTADOR_PADRAO  = 20;

endpackage

// File: rtl/debounce_botao_enter_sincronizador.sv
// Two-flop synchronizer for a single asynchronous input. The reset level
// is a parameter so the same block serves inputs with different idle levels.
module sincronizador_2ff #(
    parameter bit NIVEL_RESET = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic entrada,
    output logic saida
);

    logic estagio1;

    // Two back-to-back flops; only the second one is safe to consume
    always_ff @(posedge clock) begin
        if (!reset) begin
            estagio1 <= NIVEL_RESET;
            saida    <= NIVEL_RESET;
        end else begin
            estagio1 <= entrada;
            saida    <= estagio1;
        end
    end

endmodule

// File: rtl/debounce_botao_enter.sv
// Debounces the active-low enter push-button into a clean level (enter)
// and a one-cycle strobe (enterPulso) for the switch data-entry stage.
// Optional auto-repeat while the key is held: define REPETICAO_EN.
module debounce_botao_enter
    import pkg_entrada::*;
#(
    parameter int CICLOS_ESTAVEL    = CICLOS_ESTAVEL_PADRAO,
    parameter int LARGURA_CONTADOR  = LARGURA_CONTADOR_PADRAO,
    parameter int ATRASO_REPETICAO  = ATRASO_REPETICAO_PADRAO,
    parameter int PERIODO_REPETICAO = PERIODO_REPETICAO_PADRAO
) (
    input  logic clock,
    input  logic reset,
    input  logic botao,
    output logic enter,
    output logic enterPulso,
    output logic ocupado
);

    // Reject parameter sets the counter cannot represent
    if (CICLOS_ESTAVEL < 2) begin : gCiclosInvalido
        $error("CICLOS_ESTAVEL must be at least 2");
    end
    if (((CICLOS_ESTAVEL - 1) >> LARGURA_CONTADOR) != 0 ||
        ((ATRASO_REPETICAO - 1) >> LARGURA_CONTADOR) != 0 ||
        ((PERIODO_REPETICAO - 1) >> LARGURA_CONTADOR) != 0) begin : gLarguraInvalida
        $error("LARGURA_CONTADOR too narrow for the configured cycle counts");
    end
    if (ATRASO_REPETICAO < 2 || PERIODO_REPETICAO < 2) begin : gRepeticaoInvalida
        $error("repeat delay and period must be at least 2 to keep pulses apart");
    end

    localparam logic [LARGURA_CONTADOR-1:0] UM             = LARGURA_CONTADOR'(1);
    localparam logic [LARGURA_CONTADOR-1:0] LIMITE_ESTAVEL = LARGURA_CONTADOR'(CICLOS_ESTAVEL - 1);
`ifdef REPETICAO_EN
    localparam logic [LARGURA_CONTADOR-1:0] LIMITE_ATRASO  = LARGURA_CONTADOR'(ATRASO_REPETICAO - 1);
    localparam logic [LARGURA_CONTADOR-1:0] LIMITE_PERIODO = LARGURA_CONTADOR'(PERIODO_REPETICAO - 1);
`endif

    logic                        botaoPressionado;
    logic                        botaoSinc;
    estado_botao_t               estado;
    estado_botao_t               estadoProx;
    logic [LARGURA_CONTADOR-1:0] contador;
    logic [LARGURA_CONTADOR-1:0] contadorProx;
    logic                        pulsoProx;
    logic                        enterProx;
    logic                        ocupadoProx;
`ifdef REPETICAO_EN
    logic                        repetindo;
    logic                        repetindoProx;
`endif

    assign botaoPressionado = ~botao;

    sincronizador_2ff #(
        .NIVEL_RESET (1'b0)
    ) uSincronizador (
        .clock   (clock),
        .reset   (reset),
        .entrada (botaoPressionado),
        .saida   (botaoSinc)
    );

    // State, counter and registered outputs advance together on each edge
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado     <= SOLTO;
            contador   <= '0;
            enter      <= 1'b0;
            enterPulso <= 1'b0;
            ocupado    <= 1'b0;
`ifdef REPETICAO_EN
            repetindo  <= 1'b0;
`endif
        end else begin
            estado     <= estadoProx;
            contador   <= contadorProx;
            enter      <= enterProx;
            enterPulso <= pulsoProx;
            ocupado    <= ocupadoProx;
`ifdef REPETICAO_EN
            repetindo  <= repetindoProx;
`endif
        end
    end

    // Next state: a level change is accepted only after CICLOS_ESTAVEL
    // further agreeing samples; any disagreeing sample aborts the attempt
    always_comb begin
        estadoProx   = estado;
        contadorProx = contador;
        pulsoProx    = 1'b0;
`ifdef REPETICAO_EN
        repetindoProx = repetindo;
`endif
        case (estado)
            SOLTO: begin
                if (botaoSinc) begin
                    estadoProx   = CONFIRMA_PRESS;
                    contadorProx = '0;
                end
            end
            CONFIRMA_PRESS: begin
                if (!botaoSinc) begin
                    estadoProx   = SOLTO;
                    contadorProx = '0;
                end else if (contador == LIMITE_ESTAVEL) begin
                    estadoProx   = PRESSIONADO;
                    contadorProx = '0;
                    pulsoProx    = 1'b1;
`ifdef REPETICAO_EN
                    repetindoProx = 1'b0;
`endif
                end else begin
                    contadorProx = contador + UM;
                end
            end
            PRESSIONADO: begin
                if (!botaoSinc) begin
                    estadoProx   = CONFIRMA_SOLTA;
                    contadorProx = '0;
`ifdef REPETICAO_EN
                    repetindoProx = 1'b0;
                end else if (contador == (repetindo ? LIMITE_PERIODO : LIMITE_ATRASO)) begin
                    contadorProx  = '0;
                    pulsoProx     = 1'b1;
                    repetindoProx = 1'b1;
                end else begin
                    contadorProx = contador + UM;
`endif
                end
            end
            CONFIRMA_SOLTA: begin
                if (botaoSinc) begin
                    estadoProx   = PRESSIONADO;
                    contadorProx = '0;
`ifdef REPETICAO_EN
                    repetindoProx = 1'b0;
`endif
                end else if (contador == LIMITE_ESTAVEL) begin
                    estadoProx   = SOLTO;
                    contadorProx = '0;
                end else begin
                    contadorProx = contador + UM;
                end
            end
            default: begin
                estadoProx   = SOLTO;
                contadorProx = '0;
            end
        endcase
    end

    // Output levels decoded from the upcoming state so they register with it
    always_comb begin
        enterProx   = (estadoProx == PRESSIONADO) || (estadoProx == CONFIRMA_SOLTA);
        ocupadoProx = (estadoProx == CONFIRMA_PRESS) || (estadoProx == CONFIRMA_SOLTA);
    end

endmodule

// File: tb/tb_debounce_botao_enter.sv
// Self-checking bench for debounce_botao_enter with short timing parameters.
// Honours REPETICAO_EN when the same macro is defined for the bench.
module tb_debounce_botao_enter;

    localparam int CICLOS  = 4;
    localparam int ATRASO  = 8;
    localparam int PERIODO = 3;
`ifdef REPETICAO_EN
    localparam int REP = 1;
`else
    localparam int REP = 0;
`endif

    logic clock = 1'b0;
    logic reset;
    logic botao;
    logic enter;
    logic enterPulso;
    logic ocupado;

    int checks = 0;
    int errors = 0;
    int dutPulsos = 0;
    bit pulsoAnterior = 1'b0;

    // Reference model state: synchronizer pipe, accepted level, run length
    // of disagreeing samples, and cycles held since the press was accepted
    bit modelValid = 1'b0;
    bit m1 = 1'b0;
    bit m2 = 1'b0;
    bit mNivel = 1'b0;
    int mRun = 0;
    int mHeld = 0;
    bit mEnter = 1'b0;
    bit mPulso = 1'b0;
    bit mOcupado = 1'b0;
    bit amostra;
    bit entrou;

    debounce_botao_enter #(
        .CICLOS_ESTAVEL    (CICLOS),
        .LARGURA_CONTADOR  (8),
        .ATRASO_REPETICAO  (ATRASO),
        .PERIODO_REPETICAO (PERIODO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .botao      (botao),
        .enter      (enter),
        .enterPulso (enterPulso),
        .ocupado    (ocupado)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", nome, atual, esperado, $time);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic applyStimulus(input logic b, input int n);
        botao = b;
        waitCycles(n);
    endtask

    // Model: a change is accepted once the synchronized input has disagreed
    // with the accepted level for CICLOS+1 consecutive samples
    always @(posedge clock) begin
        if (!reset) begin
            m1 = 1'b0; m2 = 1'b0; mNivel = 1'b0; mRun = 0; mHeld = 0;
            mEnter = 1'b0; mPulso = 1'b0; mOcupado = 1'b0;
            modelValid = 1'b1;
        end else begin
            amostra = m2;
            m2 = m1;
            m1 = ~botao;
            mPulso = 1'b0;
            entrou = 1'b0;
            if (amostra != mNivel) begin
                mRun++;
                if (mRun == CICLOS + 1) begin
                    mNivel = amostra;
                    mRun = 0;
                    if (amostra) begin
                        mPulso = 1'b1;
                        entrou = 1'b1;
                    end
                end
            end else begin
                if (mRun != 0 && mNivel) entrou = 1'b1;
                mRun = 0;
            end
            if (mNivel && mRun == 0) begin
                if (entrou) mHeld = 0;
                else mHeld++;
                if (REP == 1 && mHeld >= ATRASO && ((mHeld - ATRASO) % PERIODO) == 0)
                    mPulso = 1'b1;
            end
            mEnter = mNivel;
            mOcupado = (mRun != 0);
        end
    end

    // Every cycle after the first reset edge, DUT outputs must match the model
    always @(negedge clock) begin
        if (modelValid) begin
            checkOutput("enter", enter, mEnter);
            checkOutput("enterPulso", enterPulso, mPulso);
            checkOutput("ocupado", ocupado, mOcupado);
            checkOutput("pulso duplo", 32'(enterPulso & pulsoAnterior), 0);
            pulsoAnterior = enterPulso;
            if (enterPulso === 1'b1) dutPulsos++;
        end
    end

    // Directed scenarios with hand-computed expectations
    initial begin
        int base;
        reset = 1'b0;
        botao = 1'b1;
        waitCycles(2);
        checkOutput("reset enter", enter, 0);
        checkOutput("reset enterPulso", enterPulso, 0);
        checkOutput("reset ocupado", ocupado, 0);
        reset = 1'b1;
        waitCycles(4);

        $display("[TB] clean press");
        base = dutPulsos;
        applyStimulus(1'b0, 6);
        checkOutput("limpo enter antes", enter, 0);
        checkOutput("limpo ocupado", ocupado, 1);
        waitCycles(1);
        checkOutput("limpo enter", enter, 1);
        checkOutput("limpo pulso", enterPulso, 1);
        checkOutput("limpo ocupado fim", ocupado, 0);
        waitCycles(1);
        checkOutput("limpo pulso cai", enterPulso, 0);
        checkOutput("limpo enter mantido", enter, 1);
        waitCycles(7);
        checkOutput("limpo repeticao", enterPulso, REP);
        waitCycles(5);
        applyStimulus(1'b1, 6);
        checkOutput("soltura enter antes", enter, 1);
        checkOutput("soltura ocupado", ocupado, 1);
        waitCycles(1);
        checkOutput("soltura enter", enter, 0);
        waitCycles(4);
        checkOutput("limpo total pulsos", dutPulsos - base, (REP == 1) ? 4 : 1);

        $display("[TB] bounce on press");
        base = dutPulsos;
        applyStimulus(1'b0, 2);
        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 6);
        checkOutput("quique enter antes", enter, 0);
        waitCycles(1);
        checkOutput("quique enter", enter, 1);
        checkOutput("quique pulso", enterPulso, 1);
        waitCycles(2);
        applyStimulus(1'b1, 10);
        checkOutput("quique total pulsos", dutPulsos - base, 1);

        $display("[TB] short glitch");
        base = dutPulsos;
        applyStimulus(1'b0, 3);
        applyStimulus(1'b1, 1);
        checkOutput("glitch ocupado", ocupado, 1);
        waitCycles(8);
        checkOutput("glitch enter", enter, 0);
        checkOutput("glitch pulsos", dutPulsos - base, 0);

        $display("[TB] release with bounce");
        base = dutPulsos;
        applyStimulus(1'b0, 7);
        checkOutput("rq enter", enter, 1);
        waitCycles(1);
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 2);
        checkOutput("rq enter mantido", enter, 1);
        checkOutput("rq ocupado", ocupado, 1);
        waitCycles(4);
        applyStimulus(1'b1, 6);
        checkOutput("rq enter antes soltar", enter, 1);
        waitCycles(1);
        checkOutput("rq enter solto", enter, 0);
        waitCycles(4);
        checkOutput("rq total pulsos", dutPulsos - base, 1);

        $display("[TB] reset mid-confirm");
        base = dutPulsos;
        applyStimulus(1'b0, 4);
        checkOutput("rst ocupado antes", ocupado, 1);
        reset = 1'b0;
        waitCycles(1);
        checkOutput("rst enter", enter, 0);
        checkOutput("rst pulso", enterPulso, 0);
        checkOutput("rst ocupado", ocupado, 0);
        reset = 1'b1;
        waitCycles(6);
        checkOutput("rst enter antes", enter, 0);
        waitCycles(1);
        checkOutput("rst enter requalificado", enter, 1);
        checkOutput("rst pulso requalificado", enterPulso, 1);
        waitCycles(2);
        applyStimulus(1'b1, 10);
        checkOutput("rst total pulsos", dutPulsos - base, 1);

        $display("[TB] long hold");
        base = dutPulsos;
        applyStimulus(1'b0, 30);
        applyStimulus(1'b1, 12);
        checkOutput("longo total pulsos", dutPulsos - base, (REP == 1) ? 7 : 1);
        checkOutput("longo enter final", enter, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
